seg7_temp_scan: RTL and testbench

Parametrised successor to the team's fixed 4-digit LM75A display decoder. Accepts a signed two's-complement temperature word (LSB = 0.5 °C) and converts it with a sequential double-dabble engine. Drives a multiplexed N-digit common-anode 7-segment display with sign, leading-zero blanking, a decimal point and an out-of-range indication. Sits between the I2C temperature reader and the board display pins.

---
 rtl/seg7_pkg.sv | 49 ++++
 rtl/bin2bcd_seq.sv | 62 ++++++
 rtl/seg7_temp_scan.sv | 169 ++++++++++++++++
 tb/tb_seg7_temp_scan.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7_temp_scan display block.
// Contents: active-low 7-segment glyphs (bit order gfedcba), the conversion FSM
// state type, the BCD nibble-count helper and a digit-to-glyph decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    StIdle,
    StAbs,
    StShift,
    StCommit
  } conv_state_e;

  // ceil(width * log10(2)) + 1 BCD nibbles hold any width-bit unsigned value.
  function automatic int unsigned bcd_nibbles(input int unsigned width);
    return (width * 302 + 999) / 1000 + 1;
  endfunction

  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per cycle.
// Ports: clk/rst_n (async active-low), start_i loads bin_i when idle, busy_o high
// while shifting, done_o high during the final iteration cycle (bcd_o is valid
// from the following cycle and holds until the next start).
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int unsigned Width   = 9,
  parameter int unsigned Nibbles = bcd_nibbles(Width)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [Width-1:0]       bin_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [4*Nibbles-1:0]   bcd_o
);

  localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;

  logic [Width-1:0]     bin_q;
  logic [4*Nibbles-1:0] bcd_q;
  logic [4*Nibbles-1:0] bcd_adj;
  logic [CntW-1:0]      cnt_q;
  logic                 busy_q;
  logic                 last;

  // Add 3 to every nibble >= 5 before the shift so it carries correctly.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(Nibbles); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign last = busy_q && (cnt_q == CntW'(Width - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i && !busy_q) begin
      bin_q  <= bin_i;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bcd_q <= {bcd_adj[4*Nibbles-2:0], bin_q[Width-1]};
      bin_q <= bin_q << 1;
      cnt_q <= cnt_q + 1'b1;
      if (last) busy_q <= 1'b0;
    end
  end

  assign busy_o = busy_q;
  assign done_o = last;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg7_temp_scan.sv
// Signed temperature (LSB = 0.5 C) to multiplexed common-anode 7-segment display.
// Ports: clk, rst_n (async active-low); data_in/load sample a reading; bright sets
// the digit duty cycle; busy/done/ovf report conversion status; seg (active low,
// seg[7] = dp) and dig (active low, dig[0] = rightmost) drive the display.
// Build option: define SEG7_BRIGHTNESS_EN to enable the bright duty control;
// without it bright is ignored and each digit is on for its whole slot.
module seg7_temp_scan
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DATA_W      = 9,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  load,
  input  logic [2:0]            bright,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] dig
);

  localparam int unsigned NB   = bcd_nibbles(DATA_W);
  localparam int unsigned PadW = 4 * (NB + NUM_DIGITS);
  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);

  conv_state_e state_q, state_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W:0]   mag;
  logic              sign_q, half_q;
  logic              done_q, ovf_q, ovf_d;
  logic [4*NB-1:0]   bcd;
  logic [PadW-1:0]   bcd_pad;
  logic              bcd_last;
  logic              unused_bcd_busy;
  logic [7:0]        disp_q [NUM_DIGITS];
  logic [7:0]        disp_d [NUM_DIGITS];
  int                n_int, need;

  // Sign-extended negate in DATA_W+1 bits so the most negative input survives.
  assign mag = data_q[DATA_W-1] ? (~{data_q[DATA_W-1], data_q} + 1'b1) : {1'b0, data_q};

  bin2bcd_seq #(
    .Width   (DATA_W),
    .Nibbles (NB)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (state_q == StAbs),
    .bin_i   (mag[DATA_W:1]),
    .busy_o  (unused_bcd_busy),
    .done_o  (bcd_last),
    .bcd_o   (bcd)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (load) state_d = StAbs;
      StAbs:    state_d = StShift;
      StShift:  if (bcd_last) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      sign_q  <= 1'b0;
      half_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == StCommit);
      if (state_q == StIdle && load) data_q <= data_in;
      if (state_q == StAbs) begin
        sign_q <= data_q[DATA_W-1];
        half_q <= mag[0];
      end
    end
  end

  // Display image built from the finished BCD; only latched in COMMIT.
  always_comb begin
    bcd_pad = PadW'(bcd);
    n_int   = 1;
    for (int k = 1; k < int'(NB); k++) begin
      if (bcd_pad[4*k +: 4] != 4'd0) n_int = k + 1;
    end
    need  = n_int + 1 + (sign_q ? 1 : 0);
    ovf_d = need > int'(NUM_DIGITS);
    disp_d[0] = ovf_d ? {1'b1, SEG_MINUS} : {1'b1, half_q ? SEG_5 : SEG_0};
    for (int i = 1; i < int'(NUM_DIGITS); i++) begin
      disp_d[i] = {1'b1, SEG_BLANK};
      if (ovf_d) begin
        disp_d[i] = {1'b1, SEG_MINUS};
      end else if (i - 1 < n_int) begin
        disp_d[i] = {(i != 1), seg_of_digit(bcd_pad[4*(i-1) +: 4])};
      end else if (sign_q && (i - 1 == n_int)) begin
        disp_d[i] = {1'b1, SEG_MINUS};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        disp_q[i] <= (i == 0) ? 8'hC0 : (i == 1) ? 8'h40 : 8'hFF;
      end
    end else if (state_q == StCommit) begin
      ovf_q  <= ovf_d;
      disp_q <= disp_d;
    end
  end

  // Refresh scan: counter per slot, index wraps at NUM_DIGITS-1.
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic                  wrap, dig_on;

  always_comb begin
    wrap  = (cnt_q == CntW'(REFRESH_DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (wrap) idx_d = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
`ifdef SEG7_BRIGHTNESS_EN
    dig_on = int'(cnt_q) < ((int'(bright) + 1) * int'(REFRESH_DIV)) / 8;
`else
    dig_on = 1'b1;
`endif
    seg_d = disp_q[idx_q];
    dig_d = dig_on ? ~(NUM_DIGITS'(1) << idx_q) : '1;
  end

`ifndef SEG7_BRIGHTNESS_EN
  logic unused_bright;
  assign unused_bright = ^bright;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= 8'hFF;
      dig_q <= '1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dig_q <= dig_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign ovf  = ovf_q;
  assign seg  = seg_q;
  assign dig  = dig_q;

endmodule

// File: tb/tb_seg7_temp_scan.sv
// Self-checking bench for seg7_temp_scan: two instances (4 digits / 5 digits)
// share stimulus and are compared against an arithmetic reference model.
// Honours SEG7_BRIGHTNESS_EN when defined for the build.
module tb_seg7_temp_scan;

  localparam int unsigned DataW = 9;
  localparam int unsigned NdA = 4, RdA = 8;
  localparam int unsigned NdB = 5, RdB = 4;
  localparam logic [6:0] SegTab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             load = 1'b0;
  logic [DataW-1:0] data_in = '0;
  logic [2:0]       bright = 3'd1;
  logic             busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [7:0]       seg_a, seg_b;
  logic [NdA-1:0]   dig_a;
  logic [NdB-1:0]   dig_b;
  logic [DataW-1:0] cur = '0;
  int               checks = 0;
  int               errors = 0;
  int               edges;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  seg7_temp_scan #(.NUM_DIGITS(NdA), .DATA_W(DataW), .REFRESH_DIV(RdA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load), .bright(bright),
    .busy(busy_a), .done(done_a), .ovf(ovf_a), .seg(seg_a), .dig(dig_a)
  );

  seg7_temp_scan #(.NUM_DIGITS(NdB), .DATA_W(DataW), .REFRESH_DIV(RdB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load), .bright(bright),
    .busy(busy_b), .done(done_b), .ovf(ovf_b), .seg(seg_b), .dig(dig_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bit 8 = overflow flag, bits 7:0 = expected seg for digit position pos.
  function automatic logic [8:0] ref_digit(input logic [DataW-1:0] v, input int nd,
                                           input int pos);
    int  sv, mag2, ip, tenths, nint, need, p10;
    bit  neg;
    sv     = int'($signed(v));
    neg    = sv < 0;
    mag2   = neg ? -sv : sv;
    ip     = mag2 / 2;
    tenths = (mag2 % 2) * 5;
    nint   = 1;
    p10    = 10;
    while (ip >= p10) begin
      nint++;
      p10 *= 10;
    end
    need = 1 + nint + (neg ? 1 : 0);
    if (need > nd) return 9'h1BF;
    if (pos == 0) return {2'b01, SegTab[tenths]};
    if (pos - 1 < nint) begin
      p10 = 1;
      for (int k = 0; k < pos - 1; k++) p10 *= 10;
      return {1'b0, (pos != 1), SegTab[(ip / p10) % 10]};
    end
    if (neg && (pos - 1 == nint)) return 9'h0BF;
    return 9'h0FF;
  endfunction

  function automatic logic [31:0] ref_dig(input int p, input int nd, input int rd);
    logic [31:0] all;
    int          pos, ph;
    bit          on;
    all = (32'd1 << nd) - 1;
    if (p == 0) return all;
    pos = ((p - 1) / rd) % nd;
    ph  = (p - 1) % rd;
`ifdef SEG7_BRIGHTNESS_EN
    on = ph < ((int'(bright) + 1) * rd) / 8;
`else
    on = (ph >= 0);
`endif
    return on ? (all & ~(32'd1 << pos)) : all;
  endfunction

  task automatic check_scan(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      check_eq($sformatf("dig_a_e%0d", edges), 32'(dig_a), ref_dig(edges, NdA, RdA));
      check_eq($sformatf("dig_b_e%0d", edges), 32'(dig_b), ref_dig(edges, NdB, RdB));
    end
  endtask

  // Watch a full scan of both displays and compare every digit plus ovf.
  task automatic check_display(input string tag);
    logic [7:0] obs_a [NdA];
    logic [7:0] obs_b [NdB];
    logic [8:0] e;
    for (int i = 0; i < int'(NdA); i++) obs_a[i] = 8'h00;
    for (int i = 0; i < int'(NdB); i++) obs_b[i] = 8'h00;
    for (int c = 0; c < int'(NdA * RdA) + 2; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < int'(NdA); i++) if (dig_a == ~(NdA'(1) << i)) obs_a[i] = seg_a;
      for (int i = 0; i < int'(NdB); i++) if (dig_b == ~(NdB'(1) << i)) obs_b[i] = seg_b;
    end
    for (int i = 0; i < int'(NdA); i++) begin
      e = ref_digit(cur, NdA, i);
      check_eq($sformatf("%s_a_d%0d", tag, i), 32'(obs_a[i]), 32'(e[7:0]));
      if (i == 0) check_eq($sformatf("%s_ovf_a", tag), 32'(ovf_a), 32'(e[8]));
    end
    for (int i = 0; i < int'(NdB); i++) begin
      e = ref_digit(cur, NdB, i);
      check_eq($sformatf("%s_b_d%0d", tag, i), 32'(obs_b[i]), 32'(e[7:0]));
      if (i == 0) check_eq($sformatf("%s_ovf_b", tag), 32'(ovf_b), 32'(e[8]));
    end
  endtask

  // Called #1 after a clock edge; returns in the done cycle, #1 after its edge.
  task automatic do_load(input logic [DataW-1:0] v, input bit poke,
                         input logic [DataW-1:0] pv);
    int n;
    data_in = v;
    load    = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    check_eq("done_clear", {30'd0, done_a, done_b}, 32'd0);
    n = 0;
    while (busy_a === 1'b1 && n < 40) begin
      n++;
      load = poke && (n == 3);
      if (load) data_in = pv;
      @(posedge clk); #1;
    end
    load = 1'b0;
    check_eq($sformatf("busy_len_%h", v), n, DataW + 2);
    check_eq($sformatf("done_%h", v), {29'd0, done_a, done_b, busy_b}, 32'd6);
    cur = v;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #3;
    check_eq("rst_a", {busy_a, done_a, ovf_a, seg_a, 4'(dig_a)}, {3'b000, 8'hFF, 4'hF});
    check_eq("rst_b", {busy_b, done_b, ovf_b, seg_b, 5'(dig_b)}, {3'b000, 8'hFF, 5'h1F});
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    check_scan(48);
    check_display("reset");

    do_load(9'h192, 1'b0, '0);
    do_load(9'h0FA, 1'b0, '0);  // accepted in the done cycle of the previous load
    check_display("p125_0");
    do_load(9'h192, 1'b0, '0);
    check_display("m55_0");
    do_load(9'h1FF, 1'b0, '0);
    check_display("m0_5");
    do_load(9'h001, 1'b0, '0);
    check_display("p0_5");
    do_load(9'h100, 1'b0, '0);
    check_display("m128_0");
    do_load(9'h032, 1'b1, 9'h1F0);
    check_display("poke");

    for (int r = 0; r < 8; r++) begin
      do_load(DataW'($urandom_range(0, 511)), 1'b0, '0);
      check_display($sformatf("rnd%0d", r));
    end

    // Reset in the middle of SHIFT.
    data_in = 9'h0FA;
    load    = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_a", {busy_a, done_a, ovf_a, seg_a, 4'(dig_a)}, {3'b000, 8'hFF, 4'hF});
    check_eq("midrst_b", {busy_b, done_b, ovf_b, seg_b, 5'(dig_b)}, {3'b000, 8'hFF, 5'h1F});
    @(negedge clk) rst_n = 1'b1;
    cur = '0;
    check_scan(24);
    check_eq("midrst_busy", {30'd0, busy_a, busy_b}, 32'd0);
    check_display("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
